// File: rtl/signed_min_max_tracker_pkg.sv
// Shared types and defaults for the signed min/max tracker.
package min_max_pkg;

  localparam int N_DEF       = 32;
  localparam int COUNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no frame open
    ACCUM = 2'd1,  // frame open, folding samples into min/max
    HOLD  = 2'd2   // result presented, waiting for out_ready
  } state_e;

endpackage

// File: rtl/signed_min_max_tracker_if.sv
// Sample stream in, result handshake out.
interface signed_min_max_tracker_if
  import min_max_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) ();

  logic [N-1:0]       in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [N-1:0]       out_min;
  logic [N-1:0]       out_max;
  logic [COUNT_W-1:0] out_count;
  logic               out_valid;
  logic               out_ready;

  // Sample source / result sink side
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_min, out_max, out_count, out_valid
  );

  // Tracker side
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_min, out_max, out_count, out_valid
  );

endinterface

// File: rtl/signed_min_max_tracker_comparator_lt.sv
// Signed two's-complement strict less-than: o_lt = (a < b).
module comparator_lt #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_lt
);

  // Signed compare so 0x80000000 orders below 0x7FFFFFFF
  always_comb o_lt = $signed(i_a) < $signed(i_b);

endmodule

// File: rtl/signed_min_max_tracker.sv
// Tracks running signed min/max and a saturating sample count over a frame,
// then holds {min, max, count} on a result handshake until taken.
module signed_min_max_tracker
  import min_max_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  signed_min_max_tracker_if.slave  bus
);

  state_e             r_state;
  state_e             w_next;
  logic [N-1:0]       r_min;
  logic [N-1:0]       r_max;
  logic [COUNT_W-1:0] r_count;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_lt_min;
  logic               w_lt_max;

  // in_data < min -> new minimum
  comparator_lt #(.N(N)) LT_MIN (
    .i_a  (bus.in_data),
    .i_b  (r_min),
    .o_lt (w_lt_min)
  );

  // max < in_data -> new maximum
  comparator_lt #(.N(N)) LT_MAX (
    .i_a  (r_max),
    .i_b  (bus.in_data),
    .o_lt (w_lt_max)
  );

  // Ready depends on state only; HOLD blocks input so a sample can never
  // coincide with the result handshake.
  assign w_in_ready    = (r_state == IDLE) || (r_state == ACCUM);
  assign w_accept      = bus.in_valid & w_in_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_min   = r_min;
  assign bus.out_max   = r_max;
  assign bus.out_count = r_count;

  // Next-state: open frame on first sample, close on last, release on out_ready
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = bus.in_last ? HOLD : ACCUM;
      ACCUM:   if (w_accept && bus.in_last) w_next = HOLD;
      HOLD:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State and result registers; first sample seeds min/max, later ones fold in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_min   <= '0;
      r_max   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        if (r_state == IDLE) begin
          r_min   <= bus.in_data;
          r_max   <= bus.in_data;
          r_count <= COUNT_W'(1);
        end else begin
          if (w_lt_min) r_min <= bus.in_data;
          if (w_lt_max) r_max <= bus.in_data;
          if (r_count != '1) r_count <= r_count + COUNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_min_max_tracker.sv
// Directed bench for signed_min_max_tracker: a default-width instance and a
// COUNT_W=4 instance for count saturation.
module tb_signed_min_max_tracker;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  signed_min_max_tracker_if #(.N(32), .COUNT_W(16)) bus ();
  signed_min_max_tracker_if #(.N(32), .COUNT_W(4))  bus4 ();

  signed_min_max_tracker #(.N(32), .COUNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  signed_min_max_tracker #(.N(32), .COUNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one sample for one cycle (starting at a negedge), return at next negedge
  task automatic send(input logic [31:0] d, input logic last);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send4(input logic [31:0] d, input logic last);
    bus4.in_data  = d;
    bus4.in_valid = 1'b1;
    bus4.in_last  = last;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.in_last  = 1'b0;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic bubble(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;       // unqualified, must be ignored
    bus.in_data  = 32'd100;
    repeat (n) @(negedge clk);
    bus.in_last  = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    bus4.in_data   = '0;
    bus4.in_valid  = 1'b0;
    bus4.in_last   = 1'b0;
    bus4.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_min", bus.out_min, 32'd0);
    chk("rst_max", bus.out_max, 32'd0);
    chk("rst_count", 32'(bus.out_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: {5, -3, 12, 0}
    send(32'd5, 1'b0);
    chk("t1_noval_a", 32'(bus.out_valid), 32'd0);
    send(32'hFFFF_FFFD, 1'b0);
    send(32'd12, 1'b0);
    chk("t1_noval_b", 32'(bus.out_valid), 32'd0);
    send(32'd0, 1'b1);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1_min", bus.out_min, 32'hFFFF_FFFD);
    chk("t1_max", bus.out_max, 32'd12);
    chk("t1_count", 32'(bus.out_count), 32'd4);
    take_result();
    chk("t1_drop_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_ready_back", 32'(bus.in_ready), 32'd1);
    chk("t1_min_kept", bus.out_min, 32'hFFFF_FFFD);

    // out_ready with nothing to deliver changes nothing
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_ready_noval", 32'(bus.out_valid), 32'd0);
    chk("idle_ready_inrdy", 32'(bus.in_ready), 32'd1);

    // 2: extremes
    send(32'h8000_0000, 1'b1);
    chk("t2a_min", bus.out_min, 32'h8000_0000);
    chk("t2a_max", bus.out_max, 32'h8000_0000);
    chk("t2a_count", 32'(bus.out_count), 32'd1);
    take_result();
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h8000_0000, 1'b1);
    chk("t2b_min", bus.out_min, 32'h8000_0000);
    chk("t2b_max", bus.out_max, 32'h7FFF_FFFF);
    chk("t2b_count", 32'(bus.out_count), 32'd2);
    take_result();

    // 3: ties with bubbles
    send(32'd7, 1'b0);
    bubble(2);
    chk("t3_bubble_noval", 32'(bus.out_valid), 32'd0);
    send(32'd7, 1'b0);
    bubble(3);
    send(32'd7, 1'b1);
    chk("t3_min", bus.out_min, 32'd7);
    chk("t3_max", bus.out_max, 32'd7);
    chk("t3_count", 32'(bus.out_count), 32'd3);

    // 4: stall in HOLD with samples offered
    bus.in_data  = 32'hFFFF_FFCE;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t4_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_min", bus.out_min, 32'd7);
      chk("t4_count", 32'(bus.out_count), 32'd3);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take_result();
    chk("t4_ready_back", 32'(bus.in_ready), 32'd1);
    chk("t4_drop_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_max_kept", bus.out_max, 32'd7);

    // 5: reset mid-frame
    send(32'hFFFF_FFFF, 1'b0);
    send(32'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_min", bus.out_min, 32'd0);
    chk("t5_rst_max", bus.out_max, 32'd0);
    chk("t5_rst_count", 32'(bus.out_count), 32'd0);
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
    send(32'd2, 1'b1);
    chk("t5_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_min", bus.out_min, 32'd2);
    chk("t5_max", bus.out_max, 32'd2);
    chk("t5_count", 32'(bus.out_count), 32'd1);
    take_result();

    // 6: COUNT_W=4, 20 samples of 3*i-25 -> min -25, max 32, count saturates at 15
    for (int i = 0; i < 20; i++) begin
      send4(32'(3 * i - 25), (i == 19));
    end
    chk("t6_valid", 32'(bus4.out_valid), 32'd1);
    chk("t6_count", 32'(bus4.out_count), 32'd15);
    chk("t6_min", bus4.out_min, 32'hFFFF_FFE7);
    chk("t6_max", bus4.out_max, 32'd32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
